// File: rtl/two_stage_pipeline_if.sv
// Operation/result bundle for the two-stage ALU pipeline.
// The master issues one instruction plus two operands per clock.
// The slave returns the registered result two edges later.
interface two_stage_pipeline_if #(
  parameter int DATA_W = 32
) ();

  logic [31:0]       instruction;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [DATA_W-1:0] result;

  modport master (
    output instruction,
    output operand1,
    output operand2,
    input  result
  );

  modport slave (
    input  instruction,
    input  operand1,
    input  operand2,
    output result
  );

endinterface

// File: rtl/two_stage_pipeline.sv
// Two-stage pipelined integer ALU.
// Stage 1 captures the opcode and both operands.
// Stage 2 evaluates the ALU on the captured values and registers the result.
// A new operation is accepted every clock. There are no stalls.
// Reset is synchronous and active-low. It clears every stage and discards
// any in-flight operation.
module two_stage_pipeline #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  two_stage_pipeline_if.slave  bus
);

  localparam int SHAMT_W = $clog2(DATA_W);

  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_NOR   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SLL   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SRL   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_SRA   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SLT   = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_SLTU  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_PASSA = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_PASSB = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_EQ    = OPC_W'(14);

  // Stage-1 registers (opcode and operands).
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  // Stage-2 register (ALU result).
  logic [DATA_W-1:0] result_q, result_d;

  logic [SHAMT_W-1:0] shamt;

  // Only the low opcode field of the instruction is decoded.
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.instruction[31:OPC_W];

  // Stage-1 next state: capture the incoming operation every cycle.
  always_comb begin
    opc_d = bus.instruction[OPC_W-1:0];
    a_d   = bus.operand1;
    b_d   = bus.operand2;
  end

  // Shifts use only the low bits of operand B.
  assign shamt = b_q[SHAMT_W-1:0];

  // Stage-2 ALU. It is evaluated on the stage-1 registers.
  // All arithmetic wraps modulo 2^DATA_W. The reserved opcode yields 0.
  always_comb begin
    result_d = '0;
    unique case (opc_q)
      OP_ADD:   result_d = a_q + b_q;
      OP_SUB:   result_d = a_q - b_q;
      OP_AND:   result_d = a_q & b_q;
      OP_OR:    result_d = a_q | b_q;
      OP_XOR:   result_d = a_q ^ b_q;
      OP_NOR:   result_d = ~(a_q | b_q);
      OP_SLL:   result_d = a_q << shamt;
      OP_SRL:   result_d = a_q >> shamt;
      OP_SRA:   result_d = $signed(a_q) >>> shamt;
      OP_SLT:   result_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU:  result_d = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
      OP_MUL:   result_d = a_q * b_q;
      OP_PASSA: result_d = a_q;
      OP_PASSB: result_d = b_q;
      OP_EQ:    result_d = {{(DATA_W-1){1'b0}}, (a_q == b_q)};
      default:  result_d = '0;
    endcase
  end

  // Pipeline registers. Reset clears both stages, so in-flight ops are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      opc_q    <= opc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_two_stage_pipeline.sv
// Directed bench for the two-stage ALU pipeline.
// Each step drives one operation and advances one clock edge. The check that
// follows a step looks at the result of the operation issued one step earlier,
// which gives the two-edge latency.
module tb_two_stage_pipeline;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  two_stage_pipeline_if #(.DATA_W(32)) bus ();

  two_stage_pipeline #(.DATA_W(32), .OPC_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation on the inputs, then advance one rising edge.
  // Sampling happens on the following falling edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    bus.instruction = instr;
    bus.operand1    = a;
    bus.operand2    = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare the current result with the expected value and print one line.
  task automatic chk(input string tag, input logic [31:0] exp);
    checks++;
    assert (bus.result === exp)
      $display("check %-12s result=%08h", tag, bus.result);
    else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, bus.result, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.instruction = 32'h0;
    bus.operand1    = 32'h0;
    bus.operand2    = 32'h0;

    // Hold reset for two edges while arbitrary inputs are applied.
    step(32'h0000_0000, 32'h0000_0012, 32'h0000_0034);
    step(32'h0000_000B, 32'h0000_0099, 32'h0000_0077);
    chk("reset", 32'h0);

    // Release reset. The first result reflects the cleared stage 1 (ADD 0+0).
    reset = 1'b1;
    step(32'h0, 32'd5, 32'd3);
    chk("post_rst", 32'h0);
    step(32'h0, 32'd5, 32'd3);
    chk("add", 32'd8);
    step(32'h1, 32'd10, 32'd4);
    chk("add_hold", 32'd8);
    step(32'h1, 32'd3, 32'd5);
    chk("sub", 32'd6);
    step(32'h0, 32'hFFFF_FFFF, 32'd1);
    chk("sub_wrap", 32'hFFFF_FFFE);

    // Back-to-back ops on consecutive edges.
    step(32'h0, 32'd1, 32'd2);
    chk("add_wrap", 32'h0);
    step(32'h1, 32'd9, 32'd4);
    chk("b2b_add", 32'd3);
    step(32'h6, 32'd1, 32'd4);
    chk("b2b_sub", 32'd5);

    // Remaining opcodes, one per edge.
    step(32'h2, 32'hF0F0_FFFF, 32'h0FF0_00FF);
    chk("b2b_sll", 32'd16);
    step(32'h3, 32'h1234_0000, 32'h0000_5678);
    chk("and", 32'h00F0_00FF);
    step(32'h4, 32'hFFFF_0000, 32'h0F0F_0F0F);
    chk("or", 32'h1234_5678);
    step(32'h5, 32'h0000_FFFF, 32'h00FF_0000);
    chk("xor", 32'hF0F0_0F0F);
    step(32'h6, 32'h0000_0003, 32'hFFFF_FFE4);
    chk("nor", 32'hFF00_0000);
    step(32'h7, 32'h8000_0000, 32'h0000_001F);
    chk("sll_bhi", 32'h0000_0030);
    step(32'h8, 32'h8000_0000, 32'h0000_0004);
    chk("srl", 32'h0000_0001);
    step(32'h9, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("sra", 32'hF800_0000);
    step(32'hA, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("slt", 32'h0000_0001);
    step(32'hB, 32'h0001_0000, 32'h0001_0003);
    chk("sltu", 32'h0000_0000);
    step(32'hC, 32'hDEAD_BEEF, 32'h0000_0001);
    chk("mul", 32'h0003_0000);
    step(32'hD, 32'h0000_0001, 32'hCAFE_F00D);
    chk("passa", 32'hDEAD_BEEF);
    step(32'hE, 32'h0000_0055, 32'h0000_0055);
    chk("passb", 32'hCAFE_F00D);
    step(32'hE, 32'h0000_0055, 32'h0000_0056);
    chk("eq_true", 32'h0000_0001);
    step(32'hF, 32'h0000_0001, 32'h0000_0002);
    chk("eq_false", 32'h0000_0000);
    step(32'hFFFF_FFF0, 32'h0000_0002, 32'h0000_0003);
    chk("reserved", 32'h0000_0000);
    step(32'h0, 32'h0000_0000, 32'h0000_0000);
    chk("instr_hi", 32'h0000_0005);

    // Mid-operation reset. MUL 7*6 is in stage 1 when reset hits, so 42 never appears.
    step(32'hB, 32'd7, 32'd6);
    chk("pre_mul", 32'h0);
    reset = 1'b0;
    step(32'hB, 32'd7, 32'd6);
    chk("midop_rst", 32'h0);
    reset = 1'b1;
    step(32'h0, 32'd2, 32'd2);
    chk("rst_resume", 32'h0);
    step(32'h0, 32'd2, 32'd2);
    chk("resume_add", 32'd4);
    step(32'h0, 32'd2, 32'd2);
    chk("resume_hold", 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
